// File: rtl/input_arb_pkg.sv
// Shared types and constants for the NoC input-side arbiter.
package input_arb_pkg;

  localparam int FLIT_W = 11;
  localparam int TOK_W  = 2;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    RR       = 2'd0,
    PRI_LOW  = 2'd1,
    PRI_HIGH = 2'd2,
    HOLD     = 2'd3
  } mode_e;

  localparam logic [TOK_W-1:0] SEL_DATA1 = 2'b01;
  localparam logic [TOK_W-1:0] SEL_DATA2 = 2'b10;

endpackage

// File: rtl/input_arbiter_block_arb_pair.sv
// Two-input arbiter with mode-selected priority and a round-robin pointer.
// The pointer only advances on a grant while in round-robin mode.
module arb_pair
  import input_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  mode_e mode,
  input  logic  valid_a,
  input  logic  valid_b,
  input  logic  grant,
  output logic  req,
  output logic  win
);

  logic ptr;

  always_comb begin
    req = valid_a | valid_b;
    win = 1'b0;
    case (mode)
      RR:       win = ptr ? (valid_b | ~valid_a) : ~valid_a;
      PRI_LOW:  win = ~valid_a;
      PRI_HIGH: win = valid_b;
      HOLD:     win = 1'b0;
      default:  win = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant && (mode == RR)) begin
      ptr <= ~win;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/input_arbiter_block.sv
// Input arbiter: four inputs, two pairs, one flit forwarded per cycle plus a merge token.
// Optional per-input grant counters with INPUT_ARB_GRANT_CNT_EN.
module input_arbiter_block
  import input_arb_pkg::*;
#(
  parameter int WIDTH      = 11,
  parameter int CTRL_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [WIDTH-1:0]      in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  input  logic [WIDTH-1:0]      in3_data,
  input  logic                  in3_valid,
  output logic                  in3_ready,
  input  logic [WIDTH-1:0]      in4_data,
  input  logic                  in4_valid,
  output logic                  in4_ready,
  output logic [WIDTH-1:0]      data1_to_merge_data,
  output logic                  data1_to_merge_valid,
  input  logic                  data1_to_merge_ready,
  output logic [WIDTH-1:0]      data2_to_merge_data,
  output logic                  data2_to_merge_valid,
  input  logic                  data2_to_merge_ready,
  input  logic [CTRL_WIDTH-1:0] core_control_data,
  input  logic                  core_control_valid,
  output logic                  core_control_ready,
  output logic [CTRL_WIDTH-1:0] merge_control_out_data,
  output logic                  merge_control_out_valid,
  input  logic                  merge_control_out_ready
`ifdef INPUT_ARB_GRANT_CNT_EN
  ,
  output logic [4*16-1:0]       grant_cnt
`endif
);

  mode_e mode;
  logic  gptr;
  logic  req1, req2, win1, win2;
  logic  free1, free2, freec, elig1, elig2;
  logic  grant_any, gsel;

  assign core_control_ready = 1'b1;

  assign free1 = ~data1_to_merge_valid | data1_to_merge_ready;
  assign free2 = ~data2_to_merge_valid | data2_to_merge_ready;
  assign freec = ~merge_control_out_valid | merge_control_out_ready;
  assign elig1 = ~rst & (mode != HOLD) & free1 & freec & req1;
  assign elig2 = ~rst & (mode != HOLD) & free2 & freec & req2;

  arb_pair u_pair1 (
    .clk(clk), .rst(rst), .mode(mode), .valid_a(in1_valid), .valid_b(in2_valid),
    .grant(grant_any & ~gsel), .req(req1), .win(win1)
  );

  arb_pair u_pair2 (
    .clk(clk), .rst(rst), .mode(mode), .valid_a(in3_valid), .valid_b(in4_valid),
    .grant(grant_any & gsel), .req(req2), .win(win2)
  );

  // gsel: 0 selects group 1, 1 selects group 2; the pointer breaks ties
  always_comb begin
    grant_any = 1'b0;
    gsel      = 1'b0;
    if (elig1 && elig2) begin
      grant_any = 1'b1;
      gsel      = gptr;
    end else if (elig1) begin
      grant_any = 1'b1;
      gsel      = 1'b0;
    end else if (elig2) begin
      grant_any = 1'b1;
      gsel      = 1'b1;
    end else begin
      grant_any = 1'b0;
      gsel      = 1'b0;
    end
  end

  assign in1_ready = grant_any & ~gsel & ~win1;
  assign in2_ready = grant_any & ~gsel &  win1;
  assign in3_ready = grant_any &  gsel & ~win2;
  assign in4_ready = grant_any &  gsel &  win2;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode                    <= RR;
      gptr                    <= 1'b0;
      data1_to_merge_valid    <= 1'b0;
      data1_to_merge_data     <= '0;
      data2_to_merge_valid    <= 1'b0;
      data2_to_merge_data     <= '0;
      merge_control_out_valid <= 1'b0;
      merge_control_out_data  <= '0;
    end else begin
      if (core_control_valid) begin
        mode <= mode_e'(core_control_data);
      end
      if (grant_any && !gsel) begin
        data1_to_merge_valid <= 1'b1;
        data1_to_merge_data  <= win1 ? in2_data : in1_data;
      end else if (data1_to_merge_ready) begin
        data1_to_merge_valid <= 1'b0;
      end
      if (grant_any && gsel) begin
        data2_to_merge_valid <= 1'b1;
        data2_to_merge_data  <= win2 ? in4_data : in3_data;
      end else if (data2_to_merge_ready) begin
        data2_to_merge_valid <= 1'b0;
      end
      if (grant_any) begin
        merge_control_out_valid <= 1'b1;
        merge_control_out_data  <= gsel ? CTRL_WIDTH'(SEL_DATA2) : CTRL_WIDTH'(SEL_DATA1);
        gptr                    <= ~gsel;
      end else if (merge_control_out_ready) begin
        merge_control_out_valid <= 1'b0;
      end
    end
  end

`ifdef INPUT_ARB_GRANT_CNT_EN
  logic [15:0] cnt [4];
  logic [3:0]  fire;

  assign fire = {in4_valid & in4_ready, in3_valid & in3_ready,
                 in2_valid & in2_ready, in1_valid & in1_ready};

  // Saturating per-input accepted-flit counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt[i] <= 16'd0;
      end else if (fire[i] && (cnt[i] != 16'hFFFF)) begin
        cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_input_arbiter_block.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_input_arbiter_block;

  logic        clk;
  logic        rst;
  logic [10:0] in_data [4];
  logic [3:0]  in_valid;
  logic        in1_ready, in2_ready, in3_ready, in4_ready;
  logic [10:0] data1_to_merge_data, data2_to_merge_data;
  logic        data1_to_merge_valid, data2_to_merge_valid;
  logic [2:0]  out_ready;
  logic [1:0]  core_data;
  logic        core_valid, core_ready;
  logic [1:0]  merge_control_out_data;
  logic        merge_control_out_valid;
`ifdef INPUT_ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  input_arbiter_block dut (
    .clk(clk), .rst(rst),
    .in1_data(in_data[0]), .in1_valid(in_valid[0]), .in1_ready(in1_ready),
    .in2_data(in_data[1]), .in2_valid(in_valid[1]), .in2_ready(in2_ready),
    .in3_data(in_data[2]), .in3_valid(in_valid[2]), .in3_ready(in3_ready),
    .in4_data(in_data[3]), .in4_valid(in_valid[3]), .in4_ready(in4_ready),
    .data1_to_merge_data(data1_to_merge_data), .data1_to_merge_valid(data1_to_merge_valid),
    .data1_to_merge_ready(out_ready[0]),
    .data2_to_merge_data(data2_to_merge_data), .data2_to_merge_valid(data2_to_merge_valid),
    .data2_to_merge_ready(out_ready[1]),
    .core_control_data(core_data), .core_control_valid(core_valid),
    .core_control_ready(core_ready),
    .merge_control_out_data(merge_control_out_data),
    .merge_control_out_valid(merge_control_out_valid),
    .merge_control_out_ready(out_ready[2])
`ifdef INPUT_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] last_ready;

  // Reference model state: preferred input per pair, preferred group, output slots
  int          m_mode;
  int          m_pref [2];
  int          m_gpref;
  bit          m_v [3];
  logic [10:0] m_d [2];
  logic [1:0]  m_tok;
  int          m_cnt [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_gpref = 0; m_tok = 2'b00;
    for (int i = 0; i < 2; i++) begin m_pref[i] = 0; m_d[i] = 11'd0; end
    for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  // Winner inside group g as 0/1, or -1 when nothing can be granted
  function automatic int pick(input int g);
    int order [2];
    if (m_mode == 0) begin
      order[0] = m_pref[g];
      order[1] = 1 - m_pref[g];
    end else if (m_mode == 1) begin
      order[0] = 0; order[1] = 1;
    end else if (m_mode == 2) begin
      order[0] = 1; order[1] = 0;
    end else begin
      return -1;
    end
    for (int k = 0; k < 2; k++)
      if (in_valid[2*g + order[k]]) return order[k];
    return -1;
  endfunction

  // Granted input index 0..3, or -1
  function automatic int model_grant();
    bit ctrl_free;
    bit elig [2];
    int g;
    if (rst) return -1;
    ctrl_free = !m_v[2] || out_ready[2];
    for (int k = 0; k < 2; k++)
      elig[k] = ctrl_free && (!m_v[k] || out_ready[k]) && (pick(k) >= 0);
    if (elig[0] && elig[1]) g = m_gpref;
    else if (elig[0]) g = 0;
    else if (elig[1]) g = 1;
    else return -1;
    return 2*g + pick(g);
  endfunction

  function automatic void model_update(input int gi);
    int grp;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++)
      if (m_v[k] && out_ready[k]) m_v[k] = 1'b0;
    if (gi >= 0) begin
      grp = gi / 2;
      m_v[grp] = 1'b1;
      m_d[grp] = in_data[gi];
      m_v[2]   = 1'b1;
      m_tok    = (grp == 0) ? 2'b01 : 2'b10;
      if (m_mode == 0) m_pref[grp] = 1 - (gi % 2);
      m_gpref  = 1 - grp;
      if (m_cnt[gi] < 65535) m_cnt[gi]++;
    end
    if (core_valid) m_mode = int'(core_data);
  endfunction

  // One clock: check grants before the edge, advance model, check outputs on the falling edge
  task automatic step();
    int g;
    logic [3:0] exp_r;
    #1;
    g = model_grant();
    exp_r = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    last_ready = {in4_ready, in3_ready, in2_ready, in1_ready};
    check("ready", {60'd0, last_ready}, {60'd0, exp_r});
    @(posedge clk);
    model_update(g);
    @(negedge clk);
    check("d1_valid", {63'd0, data1_to_merge_valid}, {63'd0, m_v[0]});
    check("d2_valid", {63'd0, data2_to_merge_valid}, {63'd0, m_v[1]});
    check("ctl_valid", {63'd0, merge_control_out_valid}, {63'd0, m_v[2]});
    check("d1_data", {53'd0, data1_to_merge_data}, {53'd0, m_d[0]});
    check("d2_data", {53'd0, data2_to_merge_data}, {53'd0, m_d[1]});
    check("ctl_data", {62'd0, merge_control_out_data}, {62'd0, m_tok});
`ifdef INPUT_ARB_GRANT_CNT_EN
    for (int i = 0; i < 4; i++)
      check("grant_cnt", {48'd0, grant_cnt[16*i +: 16]}, {48'd0, 16'(m_cnt[i])});
`endif
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) in_data[i] = 11'($urandom);
  endtask

  int exp_order [4] = '{1, 4, 2, 8};
  logic [10:0] held;

  initial begin
    model_reset();
    rst = 1'b1; in_valid = 4'b0000; out_ready = 3'b111;
    core_valid = 1'b0; core_data = 2'd0; last_ready = 4'b0000;
    for (int i = 0; i < 4; i++) in_data[i] = 11'd0;
    step(); step();
    check("core_ready", {63'd0, core_ready}, 64'd1);

    // Test 1: single input, one-cycle latency
    rst = 1'b0;
    in_valid = 4'b0001; in_data[0] = 11'h055;
    step();
    check("t1_grant", {60'd0, last_ready}, 64'd1);
    check("t1_data1", {53'd0, data1_to_merge_data}, 64'h055);
    check("t1_token", {62'd0, merge_control_out_data}, 64'd1);
    in_valid = 4'b0000;
    step();

    // Test 2: round-robin order with all inputs busy
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step();
      check("t2_order", {60'd0, last_ready}, 64'(exp_order[i % 4]));
    end

    // Test 3: mode 2 starves in1
    in_valid = 4'b0000; core_valid = 1'b1; core_data = 2'd2;
    step();
    core_valid = 1'b0; in_valid = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
      check("t3_in2_only", {60'd0, last_ready}, 64'd2);
    end
    core_valid = 1'b1; core_data = 2'd0;
    step();
    core_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_data(); step(); end

    // Test 4: data1 blocked, group 2 keeps flowing
    out_ready = 3'b110; in_valid = 4'b0101;
    rand_data(); step();
    held = data1_to_merge_data;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
      check("t4_in3_only", {60'd0, last_ready}, 64'd4);
      check("t4_d1_hold", {53'd0, data1_to_merge_data}, {53'd0, held});
      check("t4_token", {62'd0, merge_control_out_data}, 64'd2);
    end

    // Test 5: control slot blocked stops all grants
    out_ready = 3'b011; in_valid = 4'b1111;
    rand_data(); step();
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
      check("t5_no_grant", {60'd0, last_ready}, 64'd0);
    end
    out_ready = 3'b111;
    for (int i = 0; i < 6; i++) begin rand_data(); step(); end

    // Test 6: hold mode with full outputs, then reset
    out_ready = 3'b000; core_valid = 1'b1; core_data = 2'd3;
    rand_data(); step();
    core_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
      check("t6_hold", {60'd0, last_ready}, 64'd0);
    end
    rst = 1'b1; step();
    check("t6_valids", {61'd0, data1_to_merge_valid, data2_to_merge_valid, merge_control_out_valid}, 64'd0);
    rst = 1'b0; out_ready = 3'b111; in_valid = 4'b0000;
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rand_data();
      in_valid   = 4'($urandom);
      out_ready  = 3'($urandom) | 3'($urandom);
      core_valid = ($urandom_range(15) == 0);
      core_data  = 2'($urandom);
      rst        = ($urandom_range(79) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
